// File: rtl/logic_updater.sv
// Conway B3/S23 generation-compute stage: one neighbourhood window in, one next-generation word out,
// two-stage pipeline with live-cell accounting and a generation-complete handshake.
module logic_updater #(
    parameter int WORD_W        = 16,
    parameter int WORDS_PER_ROW = 20,
    parameter int ROWS          = 240,
    parameter int ADDR_W        = 13,
    parameter int POP_W         = 17,
    localparam int X_W          = $clog2(WORDS_PER_ROW),
    localparam int Y_W          = $clog2(ROWS)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [WORD_W+1:0] window_in [2:0],
    input  logic [X_W-1:0]    x_in,
    input  logic [Y_W-1:0]    y_in,
    input  logic              stall_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [WORD_W-1:0] wr_data_out,
    output logic [POP_W-1:0]  population_out,
    output logic              done_out,
    output logic              busy_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;

    logic                    r_s1_valid;
    logic [WORD_W-1:0][3:0]  r_cnt;
    logic [WORD_W-1:0]       r_centre;
    logic [ADDR_W-1:0]       r_s1_addr;
    logic [POP_W-1:0]        r_acc;

    logic                    w_in_range;
    logic                    w_last;
    logic                    w_accept;
    logic [ADDR_W-1:0]       w_addr;
    logic [WORD_W-1:0][3:0]  w_cnt;
    logic [WORD_W-1:0]       w_new;
    logic [POP_W-1:0]        w_pop;
    logic [POP_W:0]          w_sum;
    logic [POP_W-1:0]        w_acc_sat;

    assign w_in_range = (32'(x_in) < WORDS_PER_ROW) && (32'(y_in) < ROWS);
    assign w_last     = (32'(x_in) == WORDS_PER_ROW - 1) && (32'(y_in) == ROWS - 1);
    // A start pulse pre-empts whatever window arrives with it.
    assign w_accept   = (r_state == S_RUN) && !start_in && !stall_in && w_in_range;
    assign w_addr     = ADDR_W'(ADDR_W'(y_in) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(x_in));

    // Window bit i+1 is cell i, so cell i's neighbourhood spans window bits i..i+2.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_cell
            assign w_cnt[gi] = 4'(window_in[0][gi]) + 4'(window_in[0][gi+1]) + 4'(window_in[0][gi+2])
                             + 4'(window_in[1][gi]) + 4'(window_in[1][gi+2])
                             + 4'(window_in[2][gi]) + 4'(window_in[2][gi+1]) + 4'(window_in[2][gi+2]);
            assign w_new[gi] = (r_cnt[gi] == 4'd3) | (r_centre[gi] & (r_cnt[gi] == 4'd2));
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WORD_W; i++) begin
            w_pop = w_pop + POP_W'(w_new[i]);
        end
    end

    assign w_sum     = {1'b0, r_acc} + {1'b0, w_pop};
    assign w_acc_sat = w_sum[POP_W] ? {POP_W{1'b1}} : w_sum[POP_W-1:0];

    always_comb begin
        w_state_next = r_state;
        if (start_in) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_accept && w_last) w_state_next = S_FLUSH;
                S_FLUSH: if (!r_s1_valid) w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state        <= S_IDLE;
            r_s1_valid     <= 1'b0;
            r_cnt          <= '0;
            r_centre       <= '0;
            r_s1_addr      <= '0;
            r_acc          <= '0;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            population_out <= '0;
            done_out       <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_cnt     <= w_cnt;
                r_centre  <= window_in[1][WORD_W:1];
                r_s1_addr <= w_addr;
            end

            // Restart drops the word sitting in stage 1 along with the count.
            wr_en_out <= r_s1_valid && !start_in;
            if (r_s1_valid && !start_in) begin
                wr_addr_out <= r_s1_addr;
                wr_data_out <= w_new;
            end

            if (start_in) begin
                r_acc <= '0;
            end else if (r_s1_valid) begin
                r_acc <= w_acc_sat;
            end

            done_out <= (w_state_next == S_DONE);
            busy_out <= (w_state_next == S_RUN) || (w_state_next == S_FLUSH);
            // DONE is entered only once stage 2 has drained, so r_acc is final here.
            if (w_state_next == S_DONE) begin
                population_out <= r_acc;
            end
        end
    end

endmodule

// File: tb/tb_logic_updater.sv
// Randomised scoreboard bench for logic_updater: stimulus pushes expected writes, a negedge
// monitor pops and compares them, and a Life-rule model supplies the expected words.
module tb_logic_updater;

    localparam int WORD_W = 16;
    localparam int WPR    = 20;
    localparam int ROWS   = 240;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stall;
    logic [17:0] win [2:0];
    logic [4:0]  x;
    logic [7:0]  y;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic [16:0] pop;
    logic        done;
    logic        busy;

    always #5 clk = ~clk;

    logic_updater dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_in      (start),
        .window_in     (win),
        .x_in          (x),
        .y_in          (y),
        .stall_in      (stall),
        .wr_en_out     (wr_en),
        .wr_addr_out   (wr_addr),
        .wr_data_out   (wr_data),
        .population_out(pop),
        .done_out      (done),
        .busy_out      (busy)
    );

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   run_m = 0;
    bit   prev_acc = 0;
    int   acc_m = 0;
    int   last_pop = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_cyc = 0;

    always @(posedge clk) cyc++;

    // Life rule straight from its definition: count the eight neighbours, then born/survive.
    function automatic logic [15:0] life(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c);
        logic [15:0] r;
        int n;
        r = '0;
        for (int i = 0; i < WORD_W; i++) begin
            n = 0;
            for (int d = 0; d < 3; d++) n += int'(a[i+d]) + int'(c[i+d]);
            n += int'(b[i]) + int'(b[i+2]);
            r[i] = (n == 3) || (b[i+1] && n == 2);
        end
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wr_en) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", wr_addr, wr_data);
            end else begin
                e = q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_write: got none expected addr %0d data %h at cycle %0d", e.addr, e.data, e.cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        stall    = 1'b1;
        prev_acc = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [17:0] r0, input logic [17:0] r1, input logic [17:0] r2,
                        input int xi, input int yi, input bit st, input bit use_k, input logic [15:0] k);
        bit   acc;
        exp_t e;
        win[0] = r0;
        win[1] = r1;
        win[2] = r2;
        x      = xi[4:0];
        y      = yi[7:0];
        stall  = st;
        acc    = run_m && !st && xi < WPR && yi < ROWS;
        if (acc) begin
            e.addr = 13'(yi * WPR + xi);
            e.data = use_k ? k : life(r0, r1, r2);
            e.cyc  = cyc + 2;
            q.push_back(e);
            acc_m += $countones(e.data);
            if (xi == WPR - 1 && yi == ROWS - 1) begin
                run_m    = 1'b0;
                last_cyc = cyc;
            end
        end
        prev_acc = acc;
        tick();
        stall = 1'b1;
    endtask

    task automatic send_rand(input int xi, input int yi, input bit st);
        send(18'($urandom), 18'($urandom), 18'($urandom), xi, yi, st, 1'b0, 16'h0);
    endtask

    // The window captured on the previous edge is still in stage 1 and gets killed.
    task automatic do_start();
        win[0] = 18'($urandom);
        win[1] = 18'($urandom);
        win[2] = 18'($urandom);
        x      = 5'd0;
        y      = 8'd0;
        stall  = 1'b0;
        start  = 1'b1;
        if (prev_acc) q.delete(q.size() - 1);
        acc_m    = 0;
        run_m    = 1'b1;
        prev_acc = 1'b0;
        tick();
        start = 1'b0;
        stall = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stall  = 1'b1;
        win[0] = '0;
        win[1] = '0;
        win[2] = '0;
        x      = '0;
        y      = '0;
        repeat (3) tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_population", pop, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // IDLE ignores windows, including one that arrives together with start.
        send_rand(3, 3, 1'b0);
        idle(3);
        do_start();
        check("busy_after_start", busy, 1);

        send(18'h0, 18'h1C, 18'h0, 0, 5, 1'b0, 1'b1, 16'h0004);
        send(18'h8, 18'h8, 18'h8, 1, 5, 1'b0, 1'b1, 16'h000E);
        send(18'h2, 18'h5, 18'h0, 2, 5, 1'b0, 1'b1, 16'h0001);
        for (int i = 0; i < 10; i++) send_rand(i, 10, i[0]);
        send_rand(25, 3, 1'b0);
        send_rand(3, 250, 1'b0);
        for (int i = 0; i < 30; i++) send_rand($urandom_range(23), $urandom_range(243), $urandom_range(3) == 0);

        // Full generation in raster order with random stalls and stray out-of-range windows.
        do_start();
        done_cnt = 0;
        for (int yy = 0; yy < ROWS; yy++) begin
            for (int xx = 0; xx < WPR; xx++) begin
                while ($urandom_range(3) == 0) send_rand($urandom_range(31), $urandom_range(255), 1'b1);
                if ($urandom_range(15) == 0) send_rand(WPR + $urandom_range(11), yy, 1'b0);
                send_rand(xx, yy, 1'b0);
            end
        end
        check("busy_in_flush", busy, 1);
        for (int i = 0; i < 20 && done_cnt == 0; i++) idle(1);
        if (done_cnt == 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done pulse expected one within 20 cycles");
        end
        check("done_cycle", done_cyc, last_cyc + 3);
        check("population", pop, acc_m);
        check("busy_after_done", busy, 0);
        idle(4);
        check("done_count", done_cnt, 1);
        last_pop = acc_m;

        // Restart mid-run: in-flight word dropped, previous population kept.
        do_start();
        for (int i = 0; i < 4; i++) send_rand(i, 7, 1'b0);
        do_start();
        check("pop_hold", pop, last_pop);
        check("busy_restart", busy, 1);
        for (int i = 0; i < 6; i++) send_rand(i + 4, 8, $urandom_range(1) == 1);

        // Synchronous reset mid-run.
        send_rand(12, 9, 1'b0);
        send_rand(13, 9, 1'b0);
        rst   = 1'b1;
        stall = 1'b1;
        if (prev_acc) q.delete(q.size() - 1);
        prev_acc = 1'b0;
        run_m    = 1'b0;
        tick();
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_population", pop, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        idle(6);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/logic_updater.md
# logic_updater

Generation-compute stage directly downstream of the logic fetcher. Consumes one 3-row neighbourhood window per cycle, applies the Conway B3/S23 rule to every cell of the centre word in a two-stage pipeline, and issues the resulting word as a write to the next-generation frame buffer. It also counts live cells of the generation and flags completion so the frame controller can swap buffers.

## Interface
Parameters:
- WORD_W, 16, cells per memory word
- WORDS_PER_ROW, 20, words per board row
- ROWS, 240, board rows
- ADDR_W, 13, write address width
- POP_W, 17, population counter width (holds WORD_W*WORDS_PER_ROW*ROWS)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle pulse, begin a generation
- window_in[2:0]  in  WORD_W+2 each  row 0 = y-1, 1 = y, 2 = y+1; bit i+1 = cell column x*WORD_W+i, bit 0 = left neighbour column, bit WORD_W+1 = right neighbour column (off-board cells arrive as 0)
- x_in  in  $clog2(WORDS_PER_ROW)  word column of window centre
- y_in  in  $clog2(ROWS)  row of window centre
- stall_in  in  1  high = window/x/y invalid this cycle
- wr_en_out  out  1  write strobe
- wr_addr_out  out  ADDR_W  y*WORDS_PER_ROW + x
- wr_data_out  out  WORD_W  next-generation word, bit i = cell i
- population_out  out  POP_W  live cells of last completed generation
- done_out  out  1  one-cycle pulse, generation fully written
- busy_out  out  1  high in RUN and FLUSH

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: windows ignored. start_in -> RUN, accumulator cleared.
- RUN: window accepted each cycle stall_in is low. Accepting x=WORDS_PER_ROW-1, y=ROWS-1 -> FLUSH.
- FLUSH: no new windows accepted; after last write leaves stage 2 -> DONE.
- DONE: done_out=1, population_out <= accumulator; next cycle -> IDLE.
- Stage 1: per cell i, 4-bit neighbour count = sum of 8 surrounding bits (3 bits of rows 0 and 2 at i..i+2, bits i and i+2 of row 1); register counts, centre bits, address (multiply-add computed here, ADDR_W bits, no overflow with defaults).
- Stage 2: new = (count==3) | (centre & count==2); register data, address, wr_en; accumulator += popcount(new) on each valid word.
- start_in in RUN/FLUSH/DONE: both pipeline valid bits killed (no write issued for in-flight windows), accumulator cleared, state RUN; population_out keeps previous value.
- start_in and a valid window in the same cycle while IDLE: window ignored.
- Windows with x or y out of range: dropped, no write, no count.
- Accumulator saturates at all-ones (unreachable with defaults).

## Timing
- Reset values: wr_en_out=0, wr_addr_out=0, wr_data_out=0, population_out=0, done_out=0, busy_out=0, state IDLE, pipeline valid bits 0.
- Window sampled at edge k -> wr_en_out/addr/data valid from edge k+2 for one cycle; latency 2, throughput 1 word/cycle.
- Stall bubbles propagate: wr_en_out low exactly in the corresponding cycle.
- Final window at edge k -> final write from k+2, done_out high from k+3 for one cycle, population_out updated at k+3.
- busy_out high from the edge after start_in until the edge that enters DONE.
- rst_in mid-generation: all outputs to reset values next edge, no further writes.

## Test plan
- Horizontal blinker: rows {0, 16'h..bits2-4 set (0x001C), 0}, x=0,y=5 -> two cycles later wr_en=1, wr_addr=100, wr_data=16'h0004.
- Vertical blinker: all three rows 0x0008 -> wr_data=16'h000E.
- Full all-zero generation (4800 windows, no stalls) -> 4800 writes, addresses 0..4799 in order, done_out pulses once 3 cycles after last window, population_out=0.
- Alternating stall_in on 10 windows -> exactly 5 writes, each 2 cycles after its accepted window, no duplicates.
- Edge bits: row1 = bit0 and bit2 set, row0 bit1 set (cell 0 born via left neighbour column) -> wr_data bit0 = 1.
- start_in mid-RUN with 2 windows in flight -> those 2 writes suppressed, accumulator cleared; rst_in mid-RUN -> wr_en_out=0 and busy_out=0 next cycle.
